icache_boot_ctrl: RTL and testbench

//  Sequences bring-up of the GPP: streams a program image into the I-Cache SRAM,

---
 rtl/icache_boot_ctrl_if.sv | 44 ++++
 rtl/icache_boot_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_icache_boot_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/icache_boot_ctrl_if.sv
// ============================================================================
// Module : icache_boot_ctrl_if
// Brief  : Loader, core and SRAM signal bundle for icache_boot_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface icache_boot_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 32
) ();
  logic          Start;
  logic          Ld_Valid;
  logic [DW-1:0] Ld_Data;
  logic          Ld_Ready;
  logic [AW-1:0] Core_Addr;
  logic          Core_En;
  logic          Core_Done;
  logic          Core_Rst;
  logic [AW-1:0] Sram_Addr;
  logic [DW-1:0] Sram_Data_I;
  logic          Sram_En;
  logic          Sram_RW;
  logic [AW:0]   Word_Cnt;
  logic          Busy;
  logic          Done;
  logic          Timeout;

  // Controller side
  modport slave (
    input  Start, Ld_Valid, Ld_Data, Core_Addr, Core_En, Core_Done,
    output Ld_Ready, Core_Rst, Sram_Addr, Sram_Data_I, Sram_En, Sram_RW,
           Word_Cnt, Busy, Done, Timeout
  );

  // Host / core / SRAM side
  modport master (
    output Start, Ld_Valid, Ld_Data, Core_Addr, Core_En, Core_Done,
    input  Ld_Ready, Core_Rst, Sram_Addr, Sram_Data_I, Sram_En, Sram_RW,
           Word_Cnt, Busy, Done, Timeout
  );
endinterface

`default_nettype wire

// File: rtl/icache_boot_ctrl.sv
// ============================================================================
// Module : icache_boot_ctrl
// Brief  : GPP bring-up: load I-Cache image, pulse core reset, hand SRAM to
//          core fetch, track Done. Macro ICACHE_BOOT_WATCHDOG_EN adds a RUN watchdog.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_boot_ctrl #(
  parameter int AW          = 8,
  parameter int DW          = 32,
  parameter int DEPTH       = 256,
  parameter int RST_CYC     = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              Clk,
  input  logic              Rst,
  icache_boot_ctrl_if.slave bus
);

  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [AW:0]    c_LAST_WORD = (AW+1)'(DEPTH - 1);
  localparam logic [RCW-1:0] c_RST_LAST  = RCW'(RST_CYC - 1);

  if (RST_CYC < 1 || DEPTH < 1 || DEPTH > 2**AW || TIMEOUT_CYC < 1) begin : g_param_check
    $error("icache_boot_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RST_CORE = 3'd2,
    S_RUN      = 3'd3,
    S_FINISH   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [AW:0]    word_cnt_q, word_cnt_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic           done_q, done_d;

  logic           ld_ready;
  logic           core_rst;
  logic           sram_en;
  logic           sram_rw;
  logic [AW-1:0]  sram_addr;
  logic [DW-1:0]  sram_data;
  logic           busy;

`ifdef ICACHE_BOOT_WATCHDOG_EN
  localparam int WCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WCW-1:0] c_WD_LAST = WCW'(TIMEOUT_CYC - 1);
  logic [WCW-1:0] wd_q, wd_d;
  logic           timeout_q, timeout_d;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      rst_cnt_q  <= '0;
      done_q     <= 1'b0;
`ifdef ICACHE_BOOT_WATCHDOG_EN
      wd_q       <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      rst_cnt_q  <= rst_cnt_d;
      done_q     <= done_d;
`ifdef ICACHE_BOOT_WATCHDOG_EN
      wd_q       <= wd_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    rst_cnt_d  = rst_cnt_q;
    done_d     = done_q;
`ifdef ICACHE_BOOT_WATCHDOG_EN
    wd_d       = wd_q;
    timeout_d  = timeout_q;
`endif
    ld_ready   = 1'b0;
    core_rst   = 1'b1;
    sram_en    = 1'b0;
    sram_rw    = 1'b0;
    sram_addr  = '0;
    sram_data  = '0;
    busy       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          state_d    = S_LOAD;
          word_cnt_d = '0;
        end
      end

      S_LOAD: begin
        busy     = 1'b1;
        ld_ready = 1'b1;
        if (bus.Ld_Valid) begin
          sram_en    = 1'b1;
          sram_rw    = 1'b1;
          sram_addr  = word_cnt_q[AW-1:0];
          sram_data  = bus.Ld_Data;
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == c_LAST_WORD) begin
            state_d   = S_RST_CORE;
            rst_cnt_d = '0;
          end
        end
      end

      S_RST_CORE: begin
        busy = 1'b1;
        if (rst_cnt_q == c_RST_LAST) begin
          state_d = S_RUN;
`ifdef ICACHE_BOOT_WATCHDOG_EN
          wd_d    = '0;
`endif
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        busy      = 1'b1;
        core_rst  = 1'b0;
        sram_en   = bus.Core_En;
        sram_addr = bus.Core_Addr;
        // Core_Done wins over a watchdog expiry in the same cycle
        if (bus.Core_Done) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
        end
`ifdef ICACHE_BOOT_WATCHDOG_EN
        else if (wd_q == c_WD_LAST) begin
          state_d   = S_FINISH;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end

      S_FINISH: begin
        if (bus.Start) begin
          state_d    = S_LOAD;
          word_cnt_d = '0;
          done_d     = 1'b0;
`ifdef ICACHE_BOOT_WATCHDOG_EN
          timeout_d  = 1'b0;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.Ld_Ready    = ld_ready;
  assign bus.Core_Rst    = core_rst;
  assign bus.Sram_En     = sram_en;
  assign bus.Sram_RW     = sram_rw;
  assign bus.Sram_Addr   = sram_addr;
  assign bus.Sram_Data_I = sram_data;
  assign bus.Word_Cnt    = word_cnt_q;
  assign bus.Busy        = busy;
  assign bus.Done        = done_q;
`ifdef ICACHE_BOOT_WATCHDOG_EN
  assign bus.Timeout     = timeout_q;
`else
  assign bus.Timeout     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_boot_ctrl.sv
// ============================================================================
// Module : tb_icache_boot_ctrl
// Brief  : Randomized self-checking bench for icache_boot_ctrl (DEPTH=8, RST_CYC=2, TIMEOUT_CYC=16).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_boot_ctrl;
  localparam int AW          = 8;
  localparam int DW          = 32;
  localparam int DEPTH       = 8;
  localparam int RST_CYC     = 2;
  localparam int TIMEOUT_CYC = 16;

  logic Clk = 1'b0;
  logic Rst;
  int   n_vec = 0;
  int   n_err = 0;

  logic [DW-1:0] img [DEPTH];
  logic [DW-1:0] mem [2**AW];

  icache_boot_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  icache_boot_ctrl #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .RST_CYC(RST_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  // SRAM behavioural model: captures every write the controller issues
  always @(posedge Clk)
    if (bus.Sram_En && bus.Sram_RW) mem[bus.Sram_Addr] <= bus.Sram_Data_I;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_start();
    bus.Start = 1'b1;
    #1;
    chk("start_pre", {bus.Ld_Ready, bus.Busy, bus.Core_Rst, bus.Sram_En}, {1'b0, 1'b0, 1'b1, 1'b0});
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic load_words(input int n, input bit pattern);
    logic [DW-1:0] d;
    int gap;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus.Ld_Valid = 1'b0;
        bus.Ld_Data  = $urandom;
        bus.Core_En  = 1'($urandom);
        #1;
        chk("ld_gap", {bus.Ld_Ready, bus.Core_Rst, bus.Busy, bus.Sram_En, bus.Word_Cnt, bus.Done, bus.Timeout},
                      {1'b1, 1'b1, 1'b1, 1'b0, 9'(k), 1'b0, 1'b0});
        tick();
      end
      d = pattern ? 32'h2008_0000 + 32'(k) : $urandom;
      bus.Ld_Valid = 1'b1;
      bus.Ld_Data  = d;
      #1;
      chk("ld_wr", {bus.Ld_Ready, bus.Core_Rst, bus.Sram_En, bus.Sram_RW, bus.Sram_Addr, bus.Sram_Data_I, bus.Word_Cnt, bus.Done},
                   {1'b1, 1'b1, 1'b1, 1'b1, 8'(k), d, 9'(k), 1'b0});
      img[k] = d;
      tick();
    end
    bus.Ld_Valid = 1'b0;
  endtask

  task automatic rst_core_phase();
    for (int c = 0; c < RST_CYC; c++) begin
      bus.Ld_Valid  = 1'b1;
      bus.Ld_Data   = $urandom;
      bus.Core_En   = 1'b1;
      bus.Core_Addr = AW'($urandom);
      #1;
      chk("rst_core", {bus.Ld_Ready, bus.Core_Rst, bus.Busy, bus.Sram_En, bus.Sram_RW, bus.Sram_Addr, bus.Sram_Data_I, bus.Word_Cnt},
                      {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 9'(DEPTH)});
      tick();
    end
    bus.Ld_Valid = 1'b0;
  endtask

  task automatic check_image();
    for (int i = 0; i < DEPTH; i++) chk("image", mem[i], img[i]);
  endtask

  // done_at = 0 means Core_Done never asserted
  task automatic run_phase(input int ncyc, input int done_at, input bit fixed, input bit poke);
    logic [AW-1:0] a;
    logic          en;
    for (int c = 1; c <= ncyc; c++) begin
      a  = (fixed && c == 1) ? 8'd3 : AW'($urandom);
      en = (fixed && c == 1) ? 1'b1 : 1'($urandom);
      bus.Core_Addr = a;
      bus.Core_En   = en;
      bus.Core_Done = (c == done_at);
      bus.Start     = poke && (c == 2);
      bus.Ld_Valid  = 1'($urandom);
      #1;
      chk("run", {bus.Core_Rst, bus.Busy, bus.Ld_Ready, bus.Sram_En, bus.Sram_RW, bus.Sram_Addr, bus.Sram_Data_I, bus.Done, bus.Timeout, bus.Word_Cnt},
                 {1'b0, 1'b1, 1'b0, en, 1'b0, a, 32'h0, 1'b0, 1'b0, 9'(DEPTH)});
      tick();
    end
    bus.Core_Done = 1'b0;
    bus.Start     = 1'b0;
    bus.Ld_Valid  = 1'b0;
  endtask

  task automatic finish_check(input bit to);
    for (int c = 0; c < 2; c++) begin
      bus.Core_En   = 1'b1;
      bus.Core_Addr = AW'($urandom);
      bus.Core_Done = 1'($urandom);
      bus.Ld_Valid  = 1'b1;
      #1;
      chk("finish", {bus.Done, bus.Timeout, bus.Core_Rst, bus.Busy, bus.Ld_Ready, bus.Sram_En, bus.Sram_RW, bus.Sram_Addr, bus.Sram_Data_I},
                    {1'b1, to, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0});
      tick();
    end
    bus.Core_Done = 1'b0;
    bus.Ld_Valid  = 1'b0;
  endtask

  task automatic boot(input bit pattern);
    do_start();
    load_words(DEPTH, pattern);
    rst_core_phase();
    check_image();
  endtask

  initial begin
    int n;
    Rst = 1'b1;
    bus.Start = 1'b0; bus.Ld_Valid = 1'b0; bus.Ld_Data = '0;
    bus.Core_Addr = '0; bus.Core_En = 1'b0; bus.Core_Done = 1'b0;
    tick();
    Rst = 1'b0;
    #1;
    chk("reset", {bus.Core_Rst, bus.Ld_Ready, bus.Sram_En, bus.Sram_RW, bus.Sram_Addr, bus.Sram_Data_I, bus.Word_Cnt, bus.Busy, bus.Done, bus.Timeout},
                 {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 9'h000, 1'b0, 1'b0, 1'b0});
    tick();

    // IDLE ignores core fetch and loader traffic
    bus.Core_En = 1'b1; bus.Core_Addr = 8'h5A; bus.Ld_Valid = 1'b1;
    #1;
    chk("idle_quiet", {bus.Sram_En, bus.Sram_Addr, bus.Ld_Ready, bus.Busy}, {1'b0, 8'h00, 1'b0, 1'b0});
    tick();
    bus.Ld_Valid = 1'b0;

    // Fixed-pattern image, short run ended by Core_Done
    boot(1'b1);
    n = $urandom_range(3, 8);
    run_phase(n, n, 1'b1, 1'b0);
    finish_check(1'b0);

    // Restart from FINISH, abort mid-load with reset; old tail of image stays
    do_start();
    load_words(4, 1'b0);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    bus.Ld_Valid = 1'b1;
    #1;
    chk("abort", {bus.Word_Cnt, bus.Busy, bus.Core_Rst, bus.Ld_Ready, bus.Sram_En, bus.Done}, {9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    tick();
    bus.Ld_Valid = 1'b0;
    check_image();

    // Full random load; Start during RUN must be ignored
    boot(1'b0);
    n = $urandom_range(4, 10);
    run_phase(n, n, 1'b0, 1'b1);
    finish_check(1'b0);

`ifdef ICACHE_BOOT_WATCHDOG_EN
    boot(1'b0);
    run_phase(TIMEOUT_CYC, 0, 1'b0, 1'b0);
    finish_check(1'b1);
    boot(1'b0);
    run_phase(TIMEOUT_CYC, TIMEOUT_CYC, 1'b0, 1'b0);
    finish_check(1'b0);
`else
    boot(1'b0);
    run_phase(3 * TIMEOUT_CYC, 3 * TIMEOUT_CYC, 1'b0, 1'b0);
    finish_check(1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench time limit");
  end

endmodule

`default_nettype wire
